operand_accumulator: RTL and testbench
======================================

// Module: operand_accumulator
// PURPOSE
//  Streaming front-end for the N-bit ripple adder: accepts operands over a valid/ready
//  handshake, sums COUNT consecutive operands into a registered accumulator through one
//  adder_nbit instance, then presents the frame total downstream with a sticky overflow flag.
//  Sits between an operand source and a result consumer.
// PARAMETERS
//  BIT_WIDTH  4  operand/accumulator width; passed to the adder_nbit instance
//  COUNT      4  operands per frame, legal range 1..2**16-1
// PORTS
//  clk           in   1          rising-edge clock, the only clock
//  rst           in   1          synchronous, active-high reset
//  clear         in   1          synchronous frame abort
//  in_valid      in   1          in_data is valid
//  in_ready      out  1          block can accept an operand this cycle
//  in_data       in   BIT_WIDTH  unsigned operand
//  out_valid     out  1          out_sum/out_overflow hold a completed frame
//  out_ready     in   1          downstream takes the result this cycle
//  out_sum       out  BIT_WIDTH  frame sum modulo 2**BIT_WIDTH
//  out_overflow  out  1          1 if any addition in the frame produced carry-out
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1.
//    All outputs stay registered-derived; there is no combinational path from in_* to out_*.
//  - States: IDLE (no operand yet), ACCUM (1..COUNT-1 accepted), HOLD (result presented).
//  - Accept = in_valid & in_ready. in_ready=1 in IDLE/ACCUM, 0 in HOLD.
//  - Adder operands: a=acc (forced 0 in IDLE), b=in_data, carry_in=0.
//    On accept: acc<=sum; ovf<=ovf|carry (IDLE: ovf<=carry); cnt<=cnt+1.
//  - Transitions: IDLE->ACCUM on accept when COUNT>1; IDLE->HOLD on accept when COUNT==1;
//    ACCUM->HOLD on the accept that makes cnt==COUNT; no accept keeps state (bubbles allowed).
//  - Latency: out_valid rises the cycle after the COUNT-th accept.
//  - HOLD: out_valid=1, out_sum=acc, out_overflow=ovf, stable until out_ready=1;
//    on out_valid&out_ready -> IDLE, acc=0, cnt=0, ovf=0. No operand accepted during HOLD.
//  - Wrap-around: sum discards bit BIT_WIDTH; overflow stays set for the rest of the frame.
//  - Priority per edge: rst > clear > handshakes. clear in any state -> IDLE, acc/cnt/ovf=0;
//    a simultaneous operand accept or result transfer is discarded (treated as not happened).
//  - rst mid-frame or in HOLD discards the frame entirely; no partial result is emitted.
//  - out_sum/out_overflow are 0 whenever out_valid=0.
// STRUCTURE
//  - accum_pkg: typedef enum logic [1:0] {IDLE, ACCUM, HOLD} accum_state_t;
//    localparam CNT_W = $clog2(COUNT+1) computed locally from COUNT.
//  - One sub-module: adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add; its overflow port is carry.
//  - Rest: state register, cnt counter, acc/ovf registers, next-state logic.
// TESTING (BIT_WIDTH=4, COUNT=4 unless noted)
//  1 rst=1 two cycles -> in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
//  2 operands 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th, sum=4'hA, ovf=0, then IDLE.
//  3 operands 8,8,1,0 -> out_sum=4'h1, out_overflow=1; next frame 1,1,1,1 -> sum=4, ovf=0.
//  4 out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, outputs stable, no operand taken.
//  5 in_valid bubbles (1,0,1,0,...) with 2,2,2,2 -> only accepts counted, sum=8; clear after 2 -> IDLE, next 1,1,1,1 -> 4.
//  6 COUNT=1: operand 4'hF -> out_valid next cycle, sum=F; rst asserted in HOLD -> out_valid=0 next cycle.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding for the operand accumulator
package accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} accum_state_t;
endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: N-bit ripple-carry adder with carry-out
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry
);
  logic [BIT_WIDTH:0] c;
  assign c[0] = carry_in;
  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign carry = c[BIT_WIDTH];
endmodule

// File: rtl/operand_accumulator.sv
// operand_accumulator: sums COUNT handshaked operands per frame and presents the total with sticky overflow
module operand_accumulator
  import accum_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_sum,
  output logic                 out_overflow
);
  localparam int CNT_W = $clog2(COUNT + 1);
  accum_state_t         state;
  logic [BIT_WIDTH-1:0] acc, a_op, sum;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 ovf, carry, accept;
  assign in_ready     = state != HOLD;
  assign out_valid    = state == HOLD;
  assign out_sum      = out_valid ? acc : '0;
  assign out_overflow = out_valid & ovf;
  assign accept       = in_valid & in_ready;
  assign cnt_nxt      = cnt + CNT_W'(1);
  assign a_op         = state == IDLE ? '0 : acc;
  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .a        (a_op),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (sum),
    .carry    (carry)
  );
  // frame state, running sum, operand count and sticky overflow; clear outranks any handshake
  always_ff @(posedge clk) begin
    if (rst || clear || (out_valid && out_ready)) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= sum;
      ovf   <= (state != IDLE && ovf) || carry;
      cnt   <= cnt_nxt;
      state <= cnt_nxt == CNT_W'(COUNT) ? HOLD : ACCUM;
    end
  end
endmodule

// File: tb/tb_operand_accumulator.sv
// tb_operand_accumulator: scoreboard bench for operand_accumulator (COUNT=4 and COUNT=1 instances)
module tb_operand_accumulator;
  logic       clk = 0;
  logic       rst, clear, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_overflow;
  logic [3:0] out_sum;
  logic       rst1, in_valid1, out_ready1;
  logic [3:0] in_data1;
  logic       in_ready1, out_valid1, out_overflow1;
  logic [3:0] out_sum1;
  logic [4:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  operand_accumulator #(.BIT_WIDTH(4), .COUNT(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_overflow(out_overflow)
  );

  operand_accumulator #(.BIT_WIDTH(4), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst1), .clear(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_overflow(out_overflow1)
  );

  task automatic put(input logic [3:0] d);
    int n = 0;
    in_valid = 1; in_data = d;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_frame(input logic [3:0] o0, o1, o2, o3, input int gap);
    logic [3:0] ops[4];
    logic [4:0] s;
    logic [3:0] acc = 0;
    logic       ovf = 0;
    ops = '{o0, o1, o2, o3};
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, acc} + {1'b0, ops[i]};
      ovf |= s[4];
      acc = s[3:0];
    end
    exp_q.push_back({ovf, acc});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid op%0d: got %b want 0", i, out_valid); end
      put(ops[i]);
      for (int g = 0; g < gap && i < 3; g++) @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL latency: out_valid=%b want 1", out_valid); end
  endtask

  task automatic get_result();
    int n = 0;
    logic [4:0] e;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!out_valid || exp_q.size() == 0) begin
      bad++; $display("FAIL result_timeout: out_valid=%b queued=%0d", out_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    total++;
    if ({out_overflow, out_sum} !== e) begin
      bad++; $display("FAIL result: got ovf=%b sum=%h want ovf=%b sum=%h", out_overflow, out_sum, e[4], e[3:0]);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    total++;
    if ({out_valid, in_ready, out_overflow, out_sum} !== 7'b0100000) begin
      bad++; $display("FAIL back_to_idle: valid=%b ready=%b ovf=%b sum=%h want 0 1 0 0", out_valid, in_ready, out_overflow, out_sum);
    end
  endtask

  task automatic test_reset();
    rst = 1; rst1 = 1; clear = 0; in_valid = 0; in_data = 0; out_ready = 0;
    in_valid1 = 0; in_data1 = 0; out_ready1 = 0;
    repeat (2) @(negedge clk);
    rst = 0; rst1 = 0;
    total++;
    if ({in_ready, out_valid, out_sum, out_overflow} !== 7'b1000000) begin
      bad++; $display("FAIL reset: ready=%b valid=%b sum=%h ovf=%b want 1 0 0 0", in_ready, out_valid, out_sum, out_overflow);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(4'd1, 4'd2, 4'd3, 4'd4, 0);
    get_result();
  endtask

  task automatic test_overflow();
    send_frame(4'd8, 4'd8, 4'd1, 4'd0, 0);
    get_result();
    send_frame(4'd1, 4'd1, 4'd1, 4'd1, 0);
    get_result();
  endtask

  task automatic test_hold_stall();
    logic [3:0] held;
    send_frame(4'd5, 4'd6, 4'd7, 4'd9, 0);
    held = out_sum;
    in_valid = 1; in_data = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held) begin
        bad++; $display("FAIL hold_stall c%0d: ready=%b valid=%b sum=%h want 0 1 %h", i, in_ready, out_valid, out_sum, held);
      end
    end
    in_valid = 0;
    get_result();
    send_frame(4'd1, 4'd1, 4'd1, 4'd1, 0);
    get_result();
  endtask

  task automatic test_bubbles_clear();
    send_frame(4'd2, 4'd2, 4'd2, 4'd2, 1);
    get_result();
    put(4'd1);
    put(4'd1);
    clear = 1; in_valid = 1; in_data = 4'd5;
    @(negedge clk);
    clear = 0; in_valid = 0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clear: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    send_frame(4'd1, 4'd1, 4'd1, 4'd1, 0);
    get_result();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left: %0d want 0", exp_q.size()); end
  endtask

  task automatic test_count_one();
    in_valid1 = 1; in_data1 = 4'hF;
    @(negedge clk);
    in_valid1 = 0;
    total++;
    if ({out_valid1, out_sum1, out_overflow1, in_ready1} !== 7'b1111100) begin
      bad++; $display("FAIL count1: valid=%b sum=%h ovf=%b ready=%b want 1 f 0 0", out_valid1, out_sum1, out_overflow1, in_ready1);
    end
    rst1 = 1;
    @(negedge clk);
    rst1 = 0;
    total++;
    if ({out_valid1, out_sum1, in_ready1} !== 6'b000001) begin
      bad++; $display("FAIL count1_rst: valid=%b sum=%h ready=%b want 0 0 1", out_valid1, out_sum1, in_ready1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_overflow();
    test_hold_stall();
    test_bubbles_clear();
    test_count_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
